seq_detect_moore_p: RTL and testbench



---
 rtl/seq_detect_moore_p_if.sv | 40 ++++
 rtl/seq_detect_moore_p.sv | 106 ++++++++++
 tb/tb_seq_detect_moore_p.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_moore_p_if.sv
// seq_detect_moore_p_if
//   Groups the data, control and status signals of the programmable Moore
//   sequence detector. The clock and reset stay as plain module ports.
//
//   Signals:
//     en        sample enable; din is consumed only when en=1
//     din       serial data bit
//     overlap   1 = overlapping detection, 0 = non-overlapping
//     load      load pat_in as the new pattern
//     pat_in    new pattern, MSB is the first bit received
//     match     high while the detector sits in the match state
//     match_cnt saturating count of match-state entries
//     pat_q     currently active pattern
//
//   Modports:
//     master    stimulus side (drives the controls, observes status)
//     slave     detector side
interface seq_detect_moore_p_if #(
    parameter int PAT_LEN = 3,
    parameter int CNT_W   = 8
);
    logic               en;
    logic               din;
    logic               overlap;
    logic               load;
    logic [PAT_LEN-1:0] pat_in;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic [PAT_LEN-1:0] pat_q;

    modport master (
        output en, din, overlap, load, pat_in,
        input  match, match_cnt, pat_q
    );

    modport slave (
        input  en, din, overlap, load, pat_in,
        output match, match_cnt, pat_q
    );
endinterface

// File: rtl/seq_detect_moore_p.sv
// seq_detect_moore_p
//   Parametrised, run-time programmable Moore serial sequence detector.
//   The state is the number of pattern prefix bits currently matched
//   (0..PAT_LEN); PAT_LEN is the match state. On a mismatch the state falls
//   back to the longest pattern prefix that is still a suffix of the
//   received bits (KMP style) rather than restarting at 0.
//
//   Ports:
//     clk   clock, all state changes on the rising edge
//     rst   synchronous active-high reset (priority over load and en)
//     bus   seq_detect_moore_p_if.slave:
//             en, din, overlap, load, pat_in  (inputs)
//             match, match_cnt, pat_q         (outputs)
module seq_detect_moore_p #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b010,
    parameter int                 CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detect_moore_p_if.slave  bus
);
    localparam int               ST_W     = $clog2(PAT_LEN + 1);
    localparam logic [ST_W-1:0]  ST_MATCH = ST_W'(PAT_LEN);

    logic [ST_W-1:0]    st;
    logic [ST_W-1:0]    st_next;
    // Only the previous PAT_LEN-1 accepted bits are stored: together with
    // the incoming din they form the full PAT_LEN-bit comparison window.
    logic [PAT_LEN-2:0] hist;
    logic [PAT_LEN-2:0] hist_next;
    logic [PAT_LEN-2:0] hist_eff;
    logic [PAT_LEN-1:0] pat_r;
    logic [PAT_LEN-1:0] pat_next;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next;
    logic [PAT_LEN-1:0] window;
    logic [PAT_LEN-1:0] mask;
    logic [PAT_LEN-1:0] pat_slice;
    int                 base_len;
    int                 best;

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= '0;
            hist  <= '0;
            pat_r <= PATTERN;
            cnt_r <= '0;
        end else begin
            st    <= st_next;
            hist  <= hist_next;
            pat_r <= pat_next;
            cnt_r <= cnt_next;
        end
    end

    // Next-state logic. Leaving the match state in non-overlap mode starts
    // from an empty history, so only din itself can begin a new match.
    // The loop keeps the longest k whose last k bits equal the top k pattern
    // bits, bounded by one more than the current match length.
    always_comb begin
        st_next   = st;
        hist_next = hist;
        pat_next  = pat_r;
        cnt_next  = cnt_r;
        hist_eff  = '0;
        base_len  = 0;
        best      = 0;
        window    = '0;
        mask      = '0;
        pat_slice = '0;

        if (bus.load) begin
            pat_next  = bus.pat_in;
            st_next   = '0;
            hist_next = '0;
            cnt_next  = '0;
        end else if (bus.en) begin
            if (st == ST_MATCH && !bus.overlap) begin
                hist_eff = '0;
                base_len = 0;
            end else begin
                hist_eff = hist;
                base_len = int'(st);
            end
            window = {hist_eff, bus.din};
            for (int k = 1; k <= PAT_LEN; k++) begin
                mask      = {PAT_LEN{1'b1}} >> (PAT_LEN - k);
                pat_slice = pat_r >> (PAT_LEN - k);
                if (k <= base_len + 1 && ((window ^ pat_slice) & mask) == '0) begin
                    best = k;
                end
            end
            st_next   = ST_W'(best);
            hist_next = window[PAT_LEN-2:0];
            if (best == PAT_LEN && cnt_r != {CNT_W{1'b1}}) begin
                cnt_next = cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.match     = (st == ST_MATCH);
    assign bus.match_cnt = cnt_r;
    assign bus.pat_q     = pat_r;
endmodule

// File: tb/tb_seq_detect_moore_p.sv
// tb_seq_detect_moore_p
//   Drives one shared stimulus stream into three detector configurations:
//     dut_a  PAT_LEN=3 PATTERN=010  CNT_W=8
//     dut_b  PAT_LEN=4 PATTERN=1011 CNT_W=8
//     dut_c  PAT_LEN=3 PATTERN=010  CNT_W=2
//   A reference model per configuration tracks the received bit stream and
//   recomputes the match length as the longest stream suffix that is also a
//   pattern prefix.
module tb_seq_detect_moore_p;
    logic        clk;
    logic        rst;
    logic        en;
    logic        din;
    logic        overlap;
    logic        load;
    logic [15:0] pat_in;

    int n_checks = 0;
    int n_fails  = 0;

    seq_detect_moore_p_if #(.PAT_LEN(3), .CNT_W(8)) if_a ();
    seq_detect_moore_p_if #(.PAT_LEN(4), .CNT_W(8)) if_b ();
    seq_detect_moore_p_if #(.PAT_LEN(3), .CNT_W(2)) if_c ();

    seq_detect_moore_p #(.PAT_LEN(3), .PATTERN(3'b010), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    seq_detect_moore_p #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));
    seq_detect_moore_p #(.PAT_LEN(3), .PATTERN(3'b010), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave));

    assign if_a.en = en;  assign if_a.din = din;  assign if_a.overlap = overlap;
    assign if_b.en = en;  assign if_b.din = din;  assign if_b.overlap = overlap;
    assign if_c.en = en;  assign if_c.din = din;  assign if_c.overlap = overlap;
    assign if_a.load = load;  assign if_a.pat_in = pat_in[2:0];
    assign if_b.load = load;  assign if_b.pat_in = pat_in[3:0];
    assign if_c.load = load;  assign if_c.pat_in = pat_in[2:0];

    // Observed values gathered into arrays so checks can loop over DUTs.
    logic obs_match [3];
    int   obs_cnt   [3];
    int   obs_pat   [3];
    int   obs_st    [3];
    assign obs_match[0] = if_a.match;
    assign obs_match[1] = if_b.match;
    assign obs_match[2] = if_c.match;
    assign obs_cnt[0]   = int'(if_a.match_cnt);
    assign obs_cnt[1]   = int'(if_b.match_cnt);
    assign obs_cnt[2]   = int'(if_c.match_cnt);
    assign obs_pat[0]   = int'(if_a.pat_q);
    assign obs_pat[1]   = int'(if_b.pat_q);
    assign obs_pat[2]   = int'(if_c.pat_q);
    assign obs_st[0]    = int'(dut_a.st);
    assign obs_st[1]    = int'(dut_b.st);
    assign obs_st[2]    = int'(dut_c.st);

    // Reference model state, one entry per configuration.
    int m_len [3] = '{3, 4, 3};
    int m_def [3] = '{2, 11, 2};
    int m_max [3] = '{255, 255, 3};
    int m_pat [3];
    int m_st  [3];
    int m_cnt [3];
    int m_hist[3];
    int m_slen[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one clock edge worth of inputs and advance every model.
    task automatic step(input logic r, input logic l, input logic e,
                        input logic d, input logic o, input logic [15:0] p);
        rst = r; load = l; en = e; din = d; overlap = o; pat_in = p;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_pat[i] = m_def[i]; m_st[i] = 0; m_cnt[i] = 0;
                m_hist[i] = 0; m_slen[i] = 0;
            end else if (l) begin
                m_pat[i] = int'(p) & ((1 << m_len[i]) - 1);
                m_st[i] = 0; m_cnt[i] = 0; m_hist[i] = 0; m_slen[i] = 0;
            end else if (e) begin
                if (m_st[i] == m_len[i] && !o) begin
                    m_hist[i] = 0;
                    m_slen[i] = 0;
                end
                m_hist[i] = ((m_hist[i] << 1) | int'(d)) & 16'hFFFF;
                m_slen[i] = (m_slen[i] < 16) ? m_slen[i] + 1 : 16;
                m_st[i] = 0;
                for (int k = 1; k <= m_len[i] && k <= m_slen[i]; k++) begin
                    if ((m_hist[i] & ((1 << k) - 1)) == (m_pat[i] >> (m_len[i] - k)))
                        m_st[i] = k;
                end
                if (m_st[i] == m_len[i] && m_cnt[i] < m_max[i])
                    m_cnt[i] = m_cnt[i] + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1, 0, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            n_checks += 3;
            if (obs_match[i] !== 1'b0) begin
                n_fails++; $display("[TB] FAIL reset_match dut%0d got %0b want 0", i, obs_match[i]);
            end
            if (obs_cnt[i] !== 0) begin
                n_fails++; $display("[TB] FAIL reset_cnt dut%0d got %0d want 0", i, obs_cnt[i]);
            end
            if (obs_pat[i] !== m_def[i]) begin
                n_fails++; $display("[TB] FAIL reset_pat dut%0d got %0h want %0h", i, obs_pat[i], m_def[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [4:0] bits = 5'b01010;
        logic [4:0] expm = 5'b00101;
        step(1, 0, 0, 0, 1, 0);
        for (int j = 0; j < 5; j++) begin
            step(0, 0, 1, bits[4-j], 1, 0);
            n_checks++;
            if (obs_match[0] !== expm[4-j]) begin
                n_fails++; $display("[TB] FAIL overlap_match edge%0d got %0b want %0b", j + 1, obs_match[0], expm[4-j]);
            end
        end
        n_checks++;
        if (obs_cnt[0] !== 2) begin
            n_fails++; $display("[TB] FAIL overlap_cnt got %0d want 2", obs_cnt[0]);
        end
    endtask

    task automatic test_non_overlap();
        logic [4:0] bits = 5'b01010;
        logic [4:0] expm = 5'b00100;
        step(1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 5; j++) begin
            step(0, 0, 1, bits[4-j], 0, 0);
            n_checks++;
            if (obs_match[0] !== expm[4-j]) begin
                n_fails++; $display("[TB] FAIL nonoverlap_match edge%0d got %0b want %0b", j + 1, obs_match[0], expm[4-j]);
            end
        end
        n_checks += 2;
        if (obs_cnt[0] !== 1) begin
            n_fails++; $display("[TB] FAIL nonoverlap_cnt got %0d want 1", obs_cnt[0]);
        end
        if (obs_st[0] !== 1) begin
            n_fails++; $display("[TB] FAIL nonoverlap_st got %0d want 1", obs_st[0]);
        end
    endtask

    // Pattern 1011 on 101011: after 1010 the suffix 10 is a pattern prefix,
    // so the state falls back to 2, which is what lets 11 complete a match.
    task automatic test_kmp_fallback();
        logic [5:0] bits = 6'b101011;
        logic [5:0] expm = 6'b000001;
        step(1, 0, 0, 0, 1, 0);
        for (int j = 0; j < 6; j++) begin
            step(0, 0, 1, bits[5-j], 1, 0);
            n_checks++;
            if (obs_match[1] !== expm[5-j]) begin
                n_fails++; $display("[TB] FAIL kmp_match edge%0d got %0b want %0b", j + 1, obs_match[1], expm[5-j]);
            end
            if (j == 3) begin
                n_checks++;
                if (obs_st[1] !== 2) begin
                    n_fails++; $display("[TB] FAIL kmp_fallback_st got %0d want 2", obs_st[1]);
                end
            end
        end
        n_checks++;
        if (obs_cnt[1] !== 1) begin
            n_fails++; $display("[TB] FAIL kmp_cnt got %0d want 1", obs_cnt[1]);
        end
    endtask

    task automatic test_enable_hold();
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        for (int j = 0; j < 2; j++) begin
            step(0, 0, 0, 1, 1, 0);
            n_checks += 2;
            if (obs_st[0] !== 2) begin
                n_fails++; $display("[TB] FAIL en_hold_st cycle%0d got %0d want 2", j, obs_st[0]);
            end
            if (obs_match[0] !== 1'b0) begin
                n_fails++; $display("[TB] FAIL en_hold_match cycle%0d got %0b want 0", j, obs_match[0]);
            end
        end
        step(0, 0, 1, 0, 1, 0);
        n_checks++;
        if (obs_match[0] !== 1'b1) begin
            n_fails++; $display("[TB] FAIL en_resume_match got %0b want 1", obs_match[0]);
        end
    endtask

    task automatic test_load();
        logic [3:0] expm = 4'b0011;
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 1, 16'h0007);
        n_checks += 3;
        if (obs_st[0] !== 0) begin
            n_fails++; $display("[TB] FAIL load_st got %0d want 0", obs_st[0]);
        end
        if (obs_cnt[0] !== 0) begin
            n_fails++; $display("[TB] FAIL load_cnt got %0d want 0", obs_cnt[0]);
        end
        if (obs_pat[0] !== 7) begin
            n_fails++; $display("[TB] FAIL load_pat got %0h want 7", obs_pat[0]);
        end
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 1, 1, 1, 0);
            n_checks++;
            if (obs_match[0] !== expm[3-j]) begin
                n_fails++; $display("[TB] FAIL load_match edge%0d got %0b want %0b", j + 1, obs_match[0], expm[3-j]);
            end
        end
        n_checks++;
        if (obs_cnt[0] !== 2) begin
            n_fails++; $display("[TB] FAIL load_cnt_after got %0d want 2", obs_cnt[0]);
        end
    endtask

    task automatic test_saturation_and_reset();
        logic [9:0] bits = 10'b0101010101;
        int expc [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
        step(1, 0, 0, 0, 1, 0);
        for (int j = 0; j < 10; j++) begin
            step(0, 0, 1, bits[9-j], 1, 0);
            n_checks++;
            if (obs_cnt[2] !== expc[j]) begin
                n_fails++; $display("[TB] FAIL sat_cnt edge%0d got %0d want %0d", j + 1, obs_cnt[2], expc[j]);
            end
        end
        n_checks++;
        if (obs_st[2] !== 2) begin
            n_fails++; $display("[TB] FAIL sat_st got %0d want 2", obs_st[2]);
        end
        step(1, 0, 1, 0, 1, 0);
        n_checks += 3;
        if (obs_match[2] !== 1'b0) begin
            n_fails++; $display("[TB] FAIL midrst_match got %0b want 0", obs_match[2]);
        end
        if (obs_cnt[2] !== 0) begin
            n_fails++; $display("[TB] FAIL midrst_cnt got %0d want 0", obs_cnt[2]);
        end
        if (obs_pat[2] !== 2) begin
            n_fails++; $display("[TB] FAIL midrst_pat got %0h want 2", obs_pat[2]);
        end
    endtask

    task automatic test_random();
        logic r, l, e, d, o;
        logic [15:0] p;
        step(1, 0, 0, 0, 1, 0);
        o = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            if ($urandom_range(0, 9) == 0) o = ~o;
            p = 16'($urandom);
            step(r, l, e, d, o, p);
            for (int i = 0; i < 3; i++) begin
                n_checks += 4;
                if (obs_match[i] !== (m_st[i] == m_len[i])) begin
                    n_fails++; $display("[TB] FAIL rand_match dut%0d cyc%0d got %0b want %0b", i, cyc, obs_match[i], m_st[i] == m_len[i]);
                end
                if (obs_st[i] !== m_st[i]) begin
                    n_fails++; $display("[TB] FAIL rand_st dut%0d cyc%0d got %0d want %0d", i, cyc, obs_st[i], m_st[i]);
                end
                if (obs_cnt[i] !== m_cnt[i]) begin
                    n_fails++; $display("[TB] FAIL rand_cnt dut%0d cyc%0d got %0d want %0d", i, cyc, obs_cnt[i], m_cnt[i]);
                end
                if (obs_pat[i] !== m_pat[i]) begin
                    n_fails++; $display("[TB] FAIL rand_pat dut%0d cyc%0d got %0h want %0h", i, cyc, obs_pat[i], m_pat[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; en = 1'b0; din = 1'b0; overlap = 1'b1; pat_in = '0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_kmp_fallback();
        test_enable_hold();
        test_load();
        test_saturation_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
